// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg
//   Shared types and width helpers for the CCFF bitstream loader.
//   - state_t     : loader FSM states
//   - cnt_width() : bit-counter width, wide enough to hold CHAIN_LEN itself
//   - idx_width() : word-bit index width, at least one bit even for 1-bit words
package ccff_loader_pkg;

  localparam int DEFAULT_CHAIN_LEN = 40;
  localparam int DEFAULT_WORD_W    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  function automatic int idx_width(input int word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/ccff_word_shifter.sv
// ccff_word_shifter
//   Holds one bitstream word and serialises it LSB first.
//   Ports:
//     prog_clk  in  : programming clock
//     pReset    in  : synchronous active-high reset
//     load      in  : capture load_data, index back to 0 (wins over shift)
//     shift     in  : shift word right by one, advance index
//     load_data in  : WORD_W-bit word to capture
//     bit0      out : current serial bit (word register bit 0)
//     last_bit  out : index points at the final bit of the word
module ccff_word_shifter
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W,
  parameter int IDX_W  = idx_width(DEFAULT_WORD_W)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] load_data,
  output logic              bit0,
  output logic              last_bit
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] word_reg;
  logic [WORD_W-1:0] word_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  idx_next;

  // Per-bit next value: load, shift in from the bit above (zero at the top), or hold.
  for (genvar gi = 0; gi < WORD_W; gi++) begin : g_bit
    logic upper;
    if (gi == WORD_W - 1) begin : g_top
      assign upper = 1'b0;
    end else begin : g_mid
      assign upper = word_reg[gi+1];
    end
    assign word_next[gi] = load ? load_data[gi] : (shift ? upper : word_reg[gi]);
  end

  assign last_bit = (idx_reg == IDX_LAST);
  assign bit0     = word_reg[0];

  always_comb begin
    idx_next = idx_reg;
    if (load) begin
      idx_next = '0;
    end else if (shift) begin
      idx_next = last_bit ? '0 : idx_reg + IDX_W'(1);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      word_reg <= '0;
      idx_reg  <= '0;
    end else begin
      word_reg <= word_next;
      idx_reg  <= idx_next;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader
//   Streams word-wide configuration data onto a CCFF chain, one bit per
//   shift_en cycle, optionally checking the chain tail against the head.
//   Ports:
//     prog_clk, pReset         : clock, synchronous active-high reset
//     start, verify            : begin a pass (IDLE only); verify sampled with start
//     word_data/valid/ready    : bitstream source handshake, LSB shifted first
//     ccff_head, shift_en      : serial data and advance strobe to the chain
//     ccff_tail                : last CCFF output, used in verify mode
//     busy, done, error        : status; error is sticky until the next start
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int WORD_W    = DEFAULT_WORD_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W = cnt_width(CHAIN_LEN);
  localparam int IDX_W = idx_width(WORD_W);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             verify_reg, verify_next;
  logic             error_reg, error_next;

  logic load;
  logic shift;
  logic bit0;
  logic last_bit;
  logic last_shift;

  ccff_word_shifter #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_shifter (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .load      (load),
    .shift     (shift),
    .load_data (word_data),
    .bit0      (bit0),
    .last_bit  (last_bit)
  );

  // The shift happening this cycle is the final one of the chain.
  assign last_shift = (bit_cnt_reg == LAST_SHIFT);

  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    verify_next  = verify_reg;
    error_next   = error_reg;
    word_ready   = 1'b0;
    load         = 1'b0;
    shift        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_FETCH;
          verify_next  = verify;
          bit_cnt_next = '0;
          error_next   = 1'b0;
        end
      end

      ST_FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load       = 1'b1;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift        = 1'b1;
        bit_cnt_next = bit_cnt_reg + CNT_W'(1);
        if (verify_reg && (ccff_tail != bit0)) begin
          error_next = 1'b1;
        end
        // Chain length wins over word position: a partial final word is
        // simply abandoned and no further word is requested.
        if (last_shift) begin
          state_next = ST_DONE;
        end else if (last_bit) begin
          // Ask for the next word in the same cycle so a ready source
          // keeps the chain moving without a bubble.
          word_ready = 1'b1;
          if (word_valid) begin
            load = 1'b1;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      verify_reg  <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      verify_reg  <= verify_next;
      error_reg   <= error_next;
    end
  end

  // All of these decode registered state only; head is forced low outside
  // SHIFT so the chain input is quiet while stalled or idle.
  assign shift_en  = (state_reg == ST_SHIFT);
  assign ccff_head = shift_en & bit0;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign error     = error_reg;

endmodule
